// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: extension mode codes and default widths.
package mips_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned IMM_WIDTH  = 16;
    localparam int unsigned MODE_WIDTH = 3;

    typedef enum logic [MODE_WIDTH-1:0] {
        EXT_SIGN   = 3'd0,
        EXT_ZERO   = 3'd1,
        EXT_LUI    = 3'd2,
        EXT_BRANCH = 3'd3,
        EXT_ONES   = 3'd4
    } ext_mode_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute immediate handshake: input side (imm/mode) and output side (data/mode).
interface imm_extend_pipe_if
    import mips_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IMM_WIDTH,
    parameter int unsigned OUT_WIDTH = DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_imm;
    logic [MODE_WIDTH-1:0] in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [MODE_WIDTH-1:0] out_mode;

    // Environment side: supplies immediates and consumes results.
    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    // Stage side.
    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/imm_extend_core.sv
// Pure combinational immediate widening; reserved mode codes fall back to sign extension.
module imm_extend_core
    import mips_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IMM_WIDTH,
    parameter int unsigned OUT_WIDTH = DATA_WIDTH,
    parameter int unsigned BR_SHIFT  = 2
) (
    input  logic [IN_WIDTH-1:0]   imm,
    input  logic [MODE_WIDTH-1:0] mode,
    output logic [OUT_WIDTH-1:0]  data
);
    localparam int unsigned PAD_WIDTH = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] zero_ext;
    logic [OUT_WIDTH-1:0] sign_ext;
    logic [OUT_WIDTH-1:0] upper_ones;

    always_comb begin
        zero_ext   = OUT_WIDTH'(imm);
        sign_ext   = OUT_WIDTH'($signed(imm));
        upper_ones = ~(OUT_WIDTH'({IN_WIDTH{1'b1}}));
        data       = sign_ext;
        case (mode)
            3'(EXT_ZERO):   data = zero_ext;
            3'(EXT_LUI):    data = zero_ext << PAD_WIDTH;
            3'(EXT_BRANCH): data = sign_ext << BR_SHIFT;
            3'(EXT_ONES):   data = zero_ext | upper_ones;
            default:        data = sign_ext;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage: extend on entry, 2-entry skid buffer, transfer counter.
module imm_extend_pipe
    import mips_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IMM_WIDTH,
    parameter int unsigned OUT_WIDTH = DATA_WIDTH,
    parameter int unsigned BR_SHIFT  = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    imm_extend_pipe_if.slave     bus,
    output logic [CNT_WIDTH-1:0] xfer_count
);
    logic [1:0]            count, count_next;
    logic [OUT_WIDTH-1:0]  head_data, head_data_next, tail_data, tail_data_next;
    logic [MODE_WIDTH-1:0] head_mode, head_mode_next, tail_mode, tail_mode_next;
    logic                  ready_q, ready_next, valid_q, valid_next;
    logic [CNT_WIDTH-1:0]  xfer_next;
    logic [OUT_WIDTH-1:0]  ext_data;
    logic                  push, pop;

    imm_extend_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .BR_SHIFT  (BR_SHIFT)
    ) u_core (
        .imm  (bus.in_imm),
        .mode (bus.in_mode),
        .data (ext_data)
    );

    assign push = bus.in_valid & ready_q;
    assign pop  = valid_q & bus.out_ready;

    // Buffer update: head always feeds the output, tail only fills when the head is stalled.
    always_comb begin
        count_next     = count;
        head_data_next = head_data;
        head_mode_next = head_mode;
        tail_data_next = tail_data;
        tail_mode_next = tail_mode;
        case (count)
            2'd0: begin
                if (push) begin
                    count_next     = 2'd1;
                    head_data_next = ext_data;
                    head_mode_next = bus.in_mode;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_next = ext_data;
                    head_mode_next = bus.in_mode;
                end else if (push) begin
                    count_next     = 2'd2;
                    tail_data_next = ext_data;
                    tail_mode_next = bus.in_mode;
                end else if (pop) begin
                    count_next = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    count_next     = 2'd1;
                    head_data_next = tail_data;
                    head_mode_next = tail_mode;
                end
            end
            default: count_next = count;
        endcase
        ready_next = (count_next != 2'd2);
        valid_next = (count_next != 2'd0);
        xfer_next  = xfer_count + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 2'd0;
            head_data  <= '0;
            head_mode  <= '0;
            tail_data  <= '0;
            tail_mode  <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            xfer_count <= '0;
        end else begin
            count      <= count_next;
            head_data  <= head_data_next;
            head_mode  <= head_mode_next;
            tail_data  <= tail_data_next;
            tail_mode  <= tail_mode_next;
            ready_q    <= ready_next;
            valid_q    <= valid_next;
            xfer_count <= xfer_next;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = head_data;
    assign bus.out_mode  = head_mode;

    // A stalled producer must not change the offered immediate.
    a_in_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.in_valid && !bus.in_ready) |=>
            (!bus.in_valid || ($stable(bus.in_imm) && $stable(bus.in_mode))));

    a_count_max: assert property (@(posedge clk) count <= 2'd2);
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed + random bench for imm_extend_pipe against a queue-based reference model.
module tb_imm_extend_pipe;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();
    imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus_w ();
    logic [15:0] xfer;
    logic [3:0]  xfer_w;

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2), .CNT_WIDTH(16)) dut (
        .clk (clk), .reset (reset), .bus (bus), .xfer_count (xfer));

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2), .CNT_WIDTH(4)) dut_w (
        .clk (clk), .reset (reset), .bus (bus_w), .xfer_count (xfer_w));

    typedef struct { logic [31:0] data; logic [2:0] mode; } ent_t;
    ent_t        q[$];
    int unsigned exp_xfer;
    int          vectors;
    int          miscompares;

    // Reference extension, computed as integer arithmetic on the immediate value.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [2:0] mode);
        longint u, s;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            3'd1:    return 32'(u);
            3'd2:    return 32'(u * 65536);
            3'd3:    return 32'(s * 4);
            3'd4:    return 32'(u + 64'hFFFF_0000);
            default: return 32'(s);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_state();
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("xfer_count", 32'(xfer), exp_xfer);
        if (q.size() != 0) begin
            check("out_data", bus.out_data, q[0].data);
            check("out_mode", 32'(bus.out_mode), 32'(q[0].mode));
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode, input logic rdy);
        bus.in_valid  = v;
        bus.in_imm    = imm;
        bus.in_mode   = mode;
        bus.out_ready = rdy;
    endtask

    // One clock: advance the model with what the handshake should do, then compare.
    task automatic tick();
        bit   r, push, pop;
        ent_t e;
        r      = reset;
        push   = bus.in_valid && (q.size() < 2);
        pop    = (q.size() != 0) && bus.out_ready;
        e.data = ref_ext(bus.in_imm, bus.in_mode);
        e.mode = bus.in_mode;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_xfer = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                exp_xfer = (exp_xfer + 1) & 32'h0000_FFFF;
            end
            if (push) q.push_back(e);
        end
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    logic [15:0] sweep_imm [6] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0001, 16'h8001};
    logic [2:0]  sweep_mode[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] sweep_exp [6] = '{32'hFFFF8001, 32'h00008001, 32'h80010000,
                                   32'hFFFE0004, 32'hFFFF0001, 32'hFFFF8001};

    initial begin
        bit c_done;
        int w_occ, w_cnt;
        vectors = 0; miscompares = 0; exp_xfer = 0;
        reset = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        bus_w.in_valid = 1'b0; bus_w.in_imm = '0; bus_w.in_mode = '0; bus_w.out_ready = 1'b0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_mode", 32'(bus.out_mode), 32'h0);

        // Mode sweep, one cycle latency from acceptance
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, sweep_imm[i], sweep_mode[i], 1'b1);
            tick();
            check("sweep_data", bus.out_data, sweep_exp[i]);
            check("sweep_mode", 32'(bus.out_mode), 32'(sweep_mode[i]));
            drive(1'b0, 16'h0, 3'd0, 1'b1);
            tick();
        end

        // Back-pressure: A, B fill the buffer, C waits
        do_reset();
        drive(1'b1, 16'h1234, 3'd0, 1'b0); tick();
        drive(1'b1, 16'hF00D, 3'd1, 1'b0); tick();
        check("bp_ready_drop", 32'(bus.in_ready), 32'h0);
        drive(1'b1, 16'h8765, 3'd3, 1'b0); tick(); tick();
        check("bp_hold_data", bus.out_data, 32'h00001234);
        bus.out_ready = 1'b1;
        c_done = 1'b0;
        for (int i = 0; i < 10 && !(c_done && q.size() == 0); i++) begin
            bit acc;
            acc = bus.in_valid && (q.size() < 2);
            tick();
            if (acc) begin
                bus.in_valid = 1'b0;
                c_done = 1'b1;
            end
        end
        check("bp_c_accepted", 32'(c_done), 32'h1);
        check("bp_xfer", 32'(xfer), 32'd3);

        // Simultaneous push/pop at occupancy 1
        drive(1'b1, 16'h00AA, 3'd0, 1'b0); tick();
        drive(1'b1, 16'hBEEF, 3'd2, 1'b1); tick();
        check("pp_head", bus.out_data, 32'hBEEF0000);
        check("pp_ready", 32'(bus.in_ready), 32'h1);
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();

        // Streaming random entries at full throughput
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'($urandom), 3'($urandom_range(0, 7)), 1'b1);
            tick();
        end
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();
        check("stream_xfer", 32'(xfer), 32'd100);

        // Reset with the buffer full
        drive(1'b1, 16'h1111, 3'd4, 1'b0); tick();
        drive(1'b1, 16'h2222, 3'd3, 1'b0); tick();
        bus.in_valid = 1'b0;
        do_reset();
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'h1);
        check("mid_rst_xfer", 32'(xfer), 32'h0);
        check("mid_rst_data", bus.out_data, 32'h0);
        drive(1'b1, 16'h7FFF, 3'd0, 1'b1); tick();
        check("post_rst_data", bus.out_data, 32'h00007FFF);
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();

        // Counter wrap on the 4-bit instance
        w_occ = 0; w_cnt = 0;
        bus_w.out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            bit wpush, wpop;
            bus_w.in_valid = (i < 17);
            bus_w.in_imm   = 16'($urandom);
            wpush = bus_w.in_valid && (w_occ < 2);
            wpop  = (w_occ != 0) && bus_w.out_ready;
            @(posedge clk);
            w_occ = w_occ + int'(wpush) - int'(wpop);
            w_cnt = (w_cnt + int'(wpop)) % 16;
            #1;
            check("wrap_xfer", 32'(xfer_w), 32'(w_cnt));
        end
        bus_w.in_valid = 1'b0;
        check("wrap_final", 32'(xfer_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate-extension stage for the MIPS datapath, sitting between instruction decode and the ALU operand mux.
- Widens an IN_WIDTH immediate to OUT_WIDTH using one of five modes: sign, zero, LUI upper-placement, branch-offset shift, and ones-fill.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so a stalled execute stage never drops a decoded immediate.
- Keeps a transfer counter for pipeline bring-up debug.

Parameters:
- IN_WIDTH, 16, immediate width; legal range 2..OUT_WIDTH.
- OUT_WIDTH, 32, extended result width.
- BR_SHIFT, 2, left shift applied in BRANCH mode; legal range 0..OUT_WIDTH-IN_WIDTH.
- CNT_WIDTH, 16, width of the transfer counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, immediate and mode are valid this cycle.
- in_ready, output, 1, stage can accept an entry.
- in_imm, input, IN_WIDTH, raw immediate field.
- in_mode, input, 3, extension mode code.
- out_valid, output, 1, out_data holds a valid result.
- out_ready, input, 1, consumer accepts out_data.
- out_data, output, OUT_WIDTH, extended immediate.
- out_mode, output, 3, mode that produced out_data.
- xfer_count, output, CNT_WIDTH, number of completed output transfers.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset; there is no asynchronous path.
- Mode encoding, computed combinationally on the input side before storage:
  - 0 SIGN: {(OUT_WIDTH-IN_WIDTH){imm[MSB]}, imm}.
  - 1 ZERO: zero-filled upper bits.
  - 2 LUI: {imm, (OUT_WIDTH-IN_WIDTH) zeros}.
  - 3 BRANCH: SIGN result shifted left by BR_SHIFT, truncated to OUT_WIDTH.
  - 4 ONES: upper bits set to 1.
  - 5..7 reserved: treated as SIGN; mode is stored and presented unchanged on out_mode.
- Storage: 2-entry FIFO (skid buffer) holding {data, mode}; occupancy count 0..2; head drives out_data/out_mode.
- Outputs are driven from registers; there is no combinational path from in_* to out_*.
- Flow-control signals:
  - in_ready = (count < 2), registered-equivalent (derived from count only, not from out_ready).
  - out_valid = (count != 0).
- Push/pop rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Latency: an accepted entry into an empty buffer appears on out_data the next cycle (1 cycle).
- Simultaneous events:
  - count=0, push: count becomes 1.
  - count=1, push & pop: count stays 1; head is replaced by the new entry.
  - count=1, push only: count becomes 2; new entry goes to the tail.
  - count=2: in_ready=0; pop moves tail to head and count becomes 1; no push is possible.
- Throughput is 1 entry per cycle while out_ready is held high.
- xfer_count increments by 1 on every pop and wraps from 2^CNT_WIDTH-1 to 0 without saturating.
- Reset (including mid-transfer): count=0, out_valid=0, in_ready=1, out_data=0, out_mode=0, xfer_count=0. Buffered entries are discarded.
- Inputs are ignored in the reset cycle.
- The stored payload is don't-care when out_valid=0, but the model drives 0 after reset.
- Holding: while out_valid=1 and out_ready=0, out_data and out_mode hold stable.
- Assertions:
  - in_imm and in_mode must be stable while in_valid=1 and in_ready=0.
  - count never exceeds 2.

Decomposition:
- Shared package mips_pkg holds:
  - ext_mode_t enum (EXT_SIGN=0, EXT_ZERO=1, EXT_LUI=2, EXT_BRANCH=3, EXT_ONES=4).
  - Default width constants DATA_WIDTH=32 and IMM_WIDTH=16.
- One natural sub-module, imm_extend_core: the pure combinational mode mux, parametrised on IN_WIDTH/OUT_WIDTH/BR_SHIFT.
- The skid buffer and counter stay in imm_extend_pipe.

Test Plan:
- Mode sweep with out_ready=1, one immediate per mode:
  - in_imm=16'h8001, mode SIGN -> out_data=32'hFFFF8001, one cycle after acceptance.
  - ZERO -> 32'h00008001.
  - LUI -> 32'h80010000.
  - BRANCH -> 32'hFFFE0004.
  - ONES with 16'h0001 -> 32'hFFFF0001.
  - mode 7 with 16'h8001 -> 32'hFFFF8001, out_mode=7.
- Back-pressure: out_ready=0 while pushing 3 back-to-back entries A,B,C:
  - A and B are accepted; in_ready drops after B; C is held.
  - Raising out_ready yields A,B,C in order with no loss or duplication; xfer_count=3.
- Streaming: 100 random entries with out_ready=1 and in_valid=1 continuously -> one output per cycle; count stays 1 throughout; xfer_count=100.
- Simultaneous push/pop at count=1 -> head is replaced and count stays 1; out_data shows the new entry the next cycle.
- Reset mid-operation with count=2 and reset held for one cycle -> the next cycle shows out_valid=0, in_ready=1, xfer_count=0, out_data=0. The first post-reset entry emerges after 1 cycle.
- Counter wrap with CNT_WIDTH=4: 17 transfers -> xfer_count reads 15 after the 15th transfer, 0 after the 16th, and 1 after the 17th.
